// File: rtl/sn54als153_pkg.sv
// Shared constants for the SN54ALS153-style dual 4-to-1 data selector.
package sn54als153_pkg;

    localparam int DATA_W_DEFAULT = 1;

    localparam logic [1:0] SEL_0 = 2'b00;
    localparam logic [1:0] SEL_1 = 2'b01;
    localparam logic [1:0] SEL_2 = 2'b10;
    localparam logic [1:0] SEL_3 = 2'b11;

    localparam logic STROBE_ACTIVE = 1'b0;

endpackage

// File: rtl/sn54als153_dual_mux_slice.sv
// One 4-to-1 selector section with an active-low strobe that forces the output to zero.
module mux4_strobe_slice
    import sn54als153_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [DATA_W-1:0] data3_i,
    input  logic [1:0]        sel_i,
    input  logic              strobe_i,
    output logic [DATA_W-1:0] y_o
);

    logic [DATA_W-1:0] selected;

    // An unknown select falls through to the default arm so X reaches the output.
    always_comb begin
        selected = '0;
        case (sel_i)
            SEL_0:   selected = data0_i;
            SEL_1:   selected = data1_i;
            SEL_2:   selected = data2_i;
            SEL_3:   selected = data3_i;
            default: selected = 'x;
        endcase
    end

    assign y_o = (strobe_i == STROBE_ACTIVE) ? selected : '0;

endmodule

// File: rtl/sn54als153_dual_mux.sv
// Dual 4-to-1 data selector (SN54ALS153 style) with optional registered output copies.
// Define SN54ALS153_REG_OUT_EN to make out_1Y_q/out_2Y_q real flops; otherwise they mirror the combinational outputs.
module sn54als153_dual_mux
    import sn54als153_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_A,
    input  logic              in_B,
    input  logic [DATA_W-1:0] in_C0,
    input  logic [DATA_W-1:0] in_C1,
    input  logic [DATA_W-1:0] in_C2,
    input  logic [DATA_W-1:0] in_C3,
    input  logic [DATA_W-1:0] in_D0,
    input  logic [DATA_W-1:0] in_D1,
    input  logic [DATA_W-1:0] in_D2,
    input  logic [DATA_W-1:0] in_D3,
    input  logic              in_G1,
    input  logic              in_G2,
    output logic [DATA_W-1:0] out_1Y,
    output logic [DATA_W-1:0] out_2Y,
    output logic [DATA_W-1:0] out_1Y_q,
    output logic [DATA_W-1:0] out_2Y_q
);

    logic [1:0] sel;
    assign sel = {in_A, in_B};

    mux4_strobe_slice #(.DATA_W(DATA_W)) u_sliceC (
        .data0_i  (in_C0),
        .data1_i  (in_C1),
        .data2_i  (in_C2),
        .data3_i  (in_C3),
        .sel_i    (sel),
        .strobe_i (in_G1),
        .y_o      (out_1Y)
    );

    mux4_strobe_slice #(.DATA_W(DATA_W)) u_sliceD (
        .data0_i  (in_D0),
        .data1_i  (in_D1),
        .data2_i  (in_D2),
        .data3_i  (in_D3),
        .sel_i    (sel),
        .strobe_i (in_G2),
        .y_o      (out_2Y)
    );

`ifdef SN54ALS153_REG_OUT_EN
    logic [DATA_W-1:0] y1_d, y2_d;
    logic [DATA_W-1:0] y1_q, y2_q;

    assign y1_d = out_1Y;
    assign y2_d = out_2Y;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            y1_q <= '0;
            y2_q <= '0;
        end else begin
            y1_q <= y1_d;
            y2_q <= y2_d;
        end
    end

    assign out_1Y_q = y1_q;
    assign out_2Y_q = y2_q;
`else
    // Clock and reset stay on the port list for drop-in compatibility but drive nothing here.
    logic unusedClkRst;
    assign unusedClkRst = in_clk ^ in_rst_n;

    assign out_1Y_q = out_1Y;
    assign out_2Y_q = out_2Y;
`endif

endmodule

// File: tb/tb_sn54als153_dual_mux.sv
// Self-checking bench for sn54als153_dual_mux: 1-bit and 4-bit instances, scoreboard of expected outputs.
module tb_sn54als153_dual_mux;

    logic       clk = 1'b0;
    logic       rstN;
    logic       a, b, g1, g2;
    logic       cIn [4];
    logic       dIn [4];
    logic [3:0] cw  [4];
    logic [3:0] dw  [4];

    logic       y1, y2, y1q, y2q;
    logic [3:0] w1, w2, w1q, w2q;

    always #5 clk = ~clk;

    sn54als153_dual_mux dut (
        .in_clk(clk), .in_rst_n(rstN), .in_A(a), .in_B(b),
        .in_C0(cIn[0]), .in_C1(cIn[1]), .in_C2(cIn[2]), .in_C3(cIn[3]),
        .in_D0(dIn[0]), .in_D1(dIn[1]), .in_D2(dIn[2]), .in_D3(dIn[3]),
        .in_G1(g1), .in_G2(g2),
        .out_1Y(y1), .out_2Y(y2), .out_1Y_q(y1q), .out_2Y_q(y2q)
    );

    sn54als153_dual_mux #(.DATA_W(4)) dutW (
        .in_clk(clk), .in_rst_n(rstN), .in_A(a), .in_B(b),
        .in_C0(cw[0]), .in_C1(cw[1]), .in_C2(cw[2]), .in_C3(cw[3]),
        .in_D0(dw[0]), .in_D1(dw[1]), .in_D2(dw[2]), .in_D3(dw[3]),
        .in_G1(g1), .in_G2(g2),
        .out_1Y(w1), .out_2Y(w2), .out_1Y_q(w1q), .out_2Y_q(w2q)
    );

    typedef struct {
        string      tag;
        int         sig;
        logic [3:0] exp;
    } sbEntry_t;

    sbEntry_t scoreboard[$];
    int checks = 0;
    int passes = 0;

    // Reference selector: strobe high wins, otherwise pick word number 2*A+B.
    function automatic logic [3:0] modelY(input logic g, input logic sa, input logic sb,
                                          input logic [3:0] x0, input logic [3:0] x1,
                                          input logic [3:0] x2, input logic [3:0] x3);
        if (g) return 4'h0;
        case ({sa, sb})
            2'b00:   return x0;
            2'b01:   return x1;
            2'b10:   return x2;
            default: return x3;
        endcase
    endfunction

    function automatic logic [3:0] observed(input int sig);
        case (sig)
            0:       return {3'b000, y1};
            1:       return {3'b000, y2};
            2:       return {3'b000, y1q};
            3:       return {3'b000, y2q};
            4:       return w1;
            5:       return w2;
            6:       return w1q;
            default: return w2q;
        endcase
    endfunction

    task automatic pushExp(input string tag, input int sig, input logic [3:0] exp);
        sbEntry_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        scoreboard.push_back(e);
    endtask

    // Queues the combinational expectations for the current input values.
    task automatic applyStimulus(input string tag);
        logic [3:0] e1, e2;
        e1 = modelY(g1, a, b, {3'b0, cIn[0]}, {3'b0, cIn[1]}, {3'b0, cIn[2]}, {3'b0, cIn[3]});
        e2 = modelY(g2, a, b, {3'b0, dIn[0]}, {3'b0, dIn[1]}, {3'b0, dIn[2]}, {3'b0, dIn[3]});
        pushExp({tag, ".1Y"}, 0, e1);
        pushExp({tag, ".2Y"}, 1, e2);
`ifndef SN54ALS153_REG_OUT_EN
        pushExp({tag, ".1Yq"}, 2, e1);
        pushExp({tag, ".2Yq"}, 3, e2);
`endif
    endtask

    task automatic checkOutput();
        sbEntry_t e;
        logic [3:0] obs;
        while (scoreboard.size() > 0) begin
            e   = scoreboard.pop_front();
            obs = observed(e.sig);
            checks++;
            assert (obs === e.exp) passes++;
            else $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        rstN = 1'b0;
        a = 1'b0; b = 1'b0; g1 = 1'b1; g2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cIn[i] = 1'b1; dIn[i] = 1'b1; cw[i] = 4'h0; dw[i] = 4'h0;
        end

        // Both strobes high: outputs forced low for every select.
        for (int s = 0; s < 4; s++) begin
            {a, b} = s[1:0];
            #1 applyStimulus($sformatf("strobeOff.sel%0d", s));
            #1 checkOutput();
        end

        // Section 1 walk with section 2 disabled.
        g1 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            {a, b} = s[1:0];
            for (int i = 0; i < 4; i++) cIn[i] = ~s[0];
            for (int v = 0; v < 2; v++) begin
                cIn[s] = v[0];
                #1 applyStimulus($sformatf("walkC.sel%0d.v%0d", s, v));
                #1 checkOutput();
            end
        end

        // Section 2 walk with section 1 disabled.
        g1 = 1'b1; g2 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            {a, b} = s[1:0];
            for (int i = 0; i < 4; i++) dIn[i] = s[0];
            for (int v = 0; v < 2; v++) begin
                dIn[s] = v[0];
                #1 applyStimulus($sformatf("walkD.sel%0d.v%0d", s, v));
                #1 checkOutput();
            end
        end

        // Isolation: only C2 matters when A=1,B=0.
        g1 = 1'b0; g2 = 1'b1; a = 1'b1; b = 1'b0;
        cIn[0] = 1'b0; cIn[1] = 1'b0; cIn[2] = 1'b1; cIn[3] = 1'b0;
        #1 pushExp("iso.base", 0, 4'h1);
        #1 checkOutput();
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                cIn[i] = 1'b1;
                #1 pushExp($sformatf("iso.C%0dHigh", i), 0, 4'h1);
                #1 checkOutput();
            end
        end
        cIn[2] = 1'b0;
        #1 pushExp("iso.C2Low", 0, 4'h0);
        #1 checkOutput();

        // Wide instance: lanes selected together, strobe clears all bits.
        g1 = 1'b0; g2 = 1'b0; a = 1'b0; b = 1'b1;
        cw[0] = 4'h3; cw[1] = 4'hA; cw[2] = 4'h5; cw[3] = 4'hF;
        dw[0] = 4'h1; dw[1] = 4'h6; dw[2] = 4'h9; dw[3] = 4'hC;
        #1 pushExp("wide.1Y.sel1", 4, 4'hA);
        pushExp("wide.2Y.sel1", 5, 4'h6);
        #1 checkOutput();
        a = 1'b1; b = 1'b1;
        #1 pushExp("wide.1Y.sel3", 4, 4'hF);
        pushExp("wide.2Y.sel3", 5, 4'hC);
        #1 checkOutput();
        a = 1'b0; b = 1'b1; g1 = 1'b1;
        #1 pushExp("wide.1Y.strobeOff", 4, 4'h0);
        pushExp("wide.2Y.onlyG2", 5, 4'h6);
        #1 checkOutput();

`ifdef SN54ALS153_REG_OUT_EN
        // Registered copies: reset hold, one-cycle latency, asynchronous clear.
        @(negedge clk);
        rstN = 1'b0; g1 = 1'b0; g2 = 1'b1; a = 1'b0; b = 1'b0; cIn[0] = 1'b1;
        #1 pushExp("reg.rst.1Yq", 2, 4'h0);
        pushExp("reg.rst.2Yq", 3, 4'h0);
        #1 checkOutput();
        @(posedge clk); #1 pushExp("reg.rstHold.1Yq", 2, 4'h0);
        checkOutput();
        @(negedge clk); rstN = 1'b1;
        #1 pushExp("reg.released.noEdge", 2, 4'h0);
        checkOutput();
        @(posedge clk); #1 pushExp("reg.latency.1Yq", 2, 4'h1);
        pushExp("reg.latency.2Yq", 3, 4'h0);
        pushExp("reg.wide.1Yq", 6, 4'h3);
        checkOutput();
        @(negedge clk); cIn[0] = 1'b0;
        #1 pushExp("reg.beforeEdge.1Yq", 2, 4'h1);
        checkOutput();
        @(posedge clk); #1 pushExp("reg.follow0.1Yq", 2, 4'h0);
        checkOutput();
        @(negedge clk); cIn[0] = 1'b1;
        @(posedge clk); #1 pushExp("reg.follow1.1Yq", 2, 4'h1);
        checkOutput();
        #2 rstN = 1'b0;
        #1 pushExp("reg.asyncClr.1Yq", 2, 4'h0);
        pushExp("reg.asyncClr.wide", 6, 4'h0);
        checkOutput();
`else
        // Pass-through copies follow the combinational outputs with no clock.
        pushExp("pass.wide.1Yq", 6, 4'h0);
        pushExp("pass.wide.2Yq", 7, 4'h6);
        #1 checkOutput();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sn54als153_dual_mux.md
Name: sn54als153_dual_mux

Overview:
- Dual 4-line-to-1-line data selector/multiplexer modelled on the SN54ALS153.
- Two independent sections (C and D) share select inputs in_A and in_B. Each section has its own active-low strobe (in_G1, in_G2).
- Primary outputs are purely combinational. A clocked copy of each output is also provided for use in synchronous datapaths.
- Used as a leaf selector block in the glue-logic layer.

Parameters:
- DATA_W, 1, bit width of every data input and of each Y output; each bit lane is selected independently with the same select.

Ports:
- in_clk  input  1  clock for the registered output copies.
- in_rst_n  input  1  asynchronous active-low reset.
- in_A  input  1  select bit, MSB of select index.
- in_B  input  1  select bit, LSB of select index.
- in_C0..in_C3  input  DATA_W  section-1 data inputs.
- in_D0..in_D3  input  DATA_W  section-2 data inputs.
- in_G1  input  1  section-1 strobe, active low.
- in_G2  input  1  section-2 strobe, active low.
- out_1Y  output  DATA_W  section-1 combinational output.
- out_2Y  output  DATA_W  section-2 combinational output.
- out_1Y_q  output  DATA_W  section-1 registered output.
- out_2Y_q  output  DATA_W  section-2 registered output.

Behaviour:
- Select index sel = {in_A, in_B}, so sel = 2*A + B:
  - sel 0 selects C0/D0.
  - sel 1 (A=0, B=1) selects C1/D1.
  - sel 2 (A=1, B=0) selects C2/D2.
  - sel 3 selects C3/D3.
- Section 1: out_1Y = in_G1 ? 0 : C[sel].
- Section 2: out_2Y = in_G2 ? 0 : D[sel].
- Non-inverting data path; zero-cycle latency. Outputs respond to every input change with no clock and are independent of reset.
- Each section's strobe affects only its own section. Strobe high forces all DATA_W bits of that Y to 0 regardless of select and data.
- Unknown (X/Z) on in_G1/in_G2 or on the select lines propagates as X on the affected output in simulation. No X-masking.
- Registered copies:
  - On rising in_clk, out_1Y_q <= out_1Y and out_2Y_q <= out_2Y; latency 1 cycle.
  - in_rst_n low asynchronously clears out_1Y_q and out_2Y_q to 0 and holds them at 0 while low.
  - Deassertion takes effect at the next rising edge.
- No state machine, no handshake. Simultaneous select and strobe changes resolve combinationally to the final values.

Optional Feature:
- Macro SN54ALS153_REG_OUT_EN.
- Defined: out_1Y_q/out_2Y_q are flip-flops as described, with 1-cycle latency and async active-low reset to 0.
- Undefined: no flops are inferred. out_1Y_q = out_1Y and out_2Y_q = out_2Y combinationally; in_clk and in_rst_n are unused but the ports remain.

Decomposition:
- Shared package sn54als153_pkg holds:
  - localparams SEL_0..SEL_3 (2'b00..2'b11);
  - STROBE_ACTIVE = 1'b0;
  - the default DATA_W.
- One natural sub-module, mux4_strobe_slice, parameterised by DATA_W:
  - inputs: four data words, the 2-bit select, the strobe;
  - output: one Y word;
  - instantiated twice, once for C and once for D.
- Registers and the macro live in the top.

Test Plan:
- Strobes: G1=1, G2=1, all C/D=1, any A/B -> out_1Y=0 and out_2Y=0.
- Section-1 walk: G1=0; for each (A,B) in {00,01,10,11}, drive the selected Cn to 0 then 1 -> out_1Y follows Cn (0 then 1); out_2Y stays 0 while G2=1.
- Section-2 walk: G1=1, G2=0; same (A,B) sweep toggling Dn -> out_2Y follows Dn; out_1Y=0.
- Isolation: A=1, B=0, C2=1, all other C=0, G1=0 -> out_1Y=1. Changing C0, C1 or C3 leaves out_1Y=1; setting C2=0 gives out_1Y=0.
- Registered path (macro defined):
  - rst_n=0 -> out_1Y_q=out_2Y_q=0.
  - Release reset with out_1Y=1 -> out_1Y_q=1 one clock edge later.
  - Asserting rst_n mid-run clears the registered outputs without waiting for a clock edge.
- DATA_W=4: G1=0, A=0, B=1, C1=4'hA -> out_1Y=4'hA; G1=1 -> out_1Y=4'h0.
